// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: access sizes, FSM states and byte-lane constants for the memory stage
package mem_stage_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10} mem_size_t;
  typedef enum logic {IDLE, ACCESS} mem_state_t;
  localparam int LANE_W = 8;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane steering for stores, lane select/extension for loads, misalignment detect
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  a,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic        load,
  input  logic        store,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        err
);
  logic [31:0] sh;
  always_comb begin
    sh = rdata >> {a, 3'b000};
    be = size == SZ_BYTE ? BE_BYTE << a : size == SZ_HALF ? BE_HALF << a : BE_WORD;
    wdata_rep = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    rdata_ext = size == SZ_BYTE ? {{(32-LANE_W){~uns & sh[LANE_W-1]}}, sh[LANE_W-1:0]}
              : size == SZ_HALF ? {{(32-2*LANE_W){~uns & sh[2*LANE_W-1]}}, sh[2*LANE_W-1:0]}
              : rdata;
    err = (load & store) | (size == 2'b11) | (size == SZ_HALF & a[0]) | (size == SZ_WORD & |a);
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: load/store engine between execute and writeback with req/ack memory port and timeout
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_y,
  input  logic [31:0] ex_wdata,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        wb_addr_err,
  output logic        wb_bus_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  mem_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, y_q, y_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  off_q, off_d, size_q, size_d;
  logic        uns_q, uns_d, rw_q, rw_d;
  logic [4:0]  rd_q, rd_d;
  logic        wb_valid_q, wb_valid_d, wb_reg_write_q, wb_reg_write_d;
  logic        wb_addr_err_q, wb_addr_err_d, wb_bus_err_q, wb_bus_err_d;
  logic [31:0] wb_result_q, wb_result_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        idle, mem, al_err;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;
  assign idle = state_q == IDLE;
  assign mem  = ex_load | ex_store;
  // Store steering uses the incoming op; load extension uses the latched op during ACCESS.
  mem_lane_align u_align (
    .a        (idle ? ex_y[1:0] : off_q),
    .size     (idle ? ex_size : size_q),
    .uns      (idle ? ex_unsigned : uns_q),
    .load     (ex_load),
    .store    (ex_store),
    .wdata    (ex_wdata),
    .rdata    (dmem_rdata),
    .be       (al_be),
    .wdata_rep(al_wdata),
    .rdata_ext(al_rdata),
    .err      (al_err)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    req_d = req_q;
    we_d = we_q;
    addr_d = addr_q;
    be_d = be_q;
    wdata_d = wdata_q;
    y_d = y_q;
    off_d = off_q;
    size_d = size_q;
    uns_d = uns_q;
    rw_d = rw_q;
    rd_d = rd_q;
    wb_valid_d = 1'b0;
    wb_result_d = wb_result_q;
    wb_rd_d = wb_rd_q;
    wb_reg_write_d = wb_reg_write_q;
    wb_addr_err_d = wb_addr_err_q;
    wb_bus_err_d = wb_bus_err_q;
    if (idle) begin
      if (ex_valid) begin
        y_d = ex_y;
        off_d = ex_y[1:0];
        size_d = ex_size;
        uns_d = ex_unsigned;
        rw_d = ex_reg_write;
        rd_d = ex_rd;
        if (!mem || al_err) begin
          wb_valid_d = 1'b1;
          wb_result_d = ex_y;
          wb_rd_d = ex_rd;
          wb_reg_write_d = !mem & ex_reg_write;
          wb_addr_err_d = mem;
          wb_bus_err_d = 1'b0;
        end else begin
          state_d = ACCESS;
          cnt_d = '0;
          req_d = 1'b1;
          we_d = ex_store;
          addr_d = {ex_y[31:2], 2'b00};
          be_d = al_be;
          wdata_d = al_wdata;
        end
      end
    end else if (dmem_ack || cnt_q == CW'(TIMEOUT - 1)) begin
      state_d = IDLE;
      req_d = 1'b0;
      wb_valid_d = 1'b1;
      wb_result_d = (dmem_ack && !we_q) ? al_rdata : y_q;
      wb_rd_d = rd_q;
      wb_reg_write_d = dmem_ack & !we_q & rw_q;
      wb_addr_err_d = 1'b0;
      wb_bus_err_d = !dmem_ack;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      req_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
      y_q <= '0;
      off_q <= '0;
      size_q <= '0;
      uns_q <= 1'b0;
      rw_q <= 1'b0;
      rd_q <= '0;
      wb_valid_q <= 1'b0;
      wb_result_q <= '0;
      wb_rd_q <= '0;
      wb_reg_write_q <= 1'b0;
      wb_addr_err_q <= 1'b0;
      wb_bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      req_q <= req_d;
      we_q <= we_d;
      addr_q <= addr_d;
      be_q <= be_d;
      wdata_q <= wdata_d;
      y_q <= y_d;
      off_q <= off_d;
      size_q <= size_d;
      uns_q <= uns_d;
      rw_q <= rw_d;
      rd_q <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_result_q <= wb_result_d;
      wb_rd_q <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_addr_err_q <= wb_addr_err_d;
      wb_bus_err_q <= wb_bus_err_d;
    end
  end
  assign ex_ready = idle;
  assign dmem_req = req_q;
  assign dmem_we = we_q;
  assign dmem_addr = addr_q;
  assign dmem_be = be_q;
  assign dmem_wdata = wdata_q;
  assign wb_valid = wb_valid_q;
  assign wb_result = wb_result_q;
  assign wb_rd = wb_rd_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_addr_err = wb_addr_err_q;
  assign wb_bus_err = wb_bus_err_q;
endmodule
